// File: rtl/prbs_frame_checker.sv
// prbs_frame_checker
// Receive-side PRBS31 checker on the PCS receive stream. It seeds a reference
// word from the incoming data and confirms that it predicts the following
// words. After that it tracks lock and counts bit errors, frames, frames the
// PCS flagged as bad, and lock losses.
//
// Ports:
//   rx_user_clk_i    receive user clock (the only clock)
//   rx_user_rst_i    asynchronous reset, active-high
//   rx_data_i        32-bit payload, byte 0 = [7:0] first on the wire
//   rx_vldb_i        valid-byte count on last beat (0 = all four bytes)
//   rx_valid_i       beat qualifier
//   rx_last_i        last beat of frame
//   rx_user_i        PCS bad-frame flag, sampled on the last beat
//   clr_i            synchronous clear of all counters (lock unaffected)
//   lock_o           high while locked
//   err_pulse_o      one-cycle pulse per locked beat with bit errors
//   err_bit_cnt_o    saturating errored-bit count
//   frame_cnt_o      saturating frame count
//   bad_frame_cnt_o  saturating PCS-bad frame count
//   lock_loss_cnt_o  saturating lock-loss count
module prbs_frame_checker #(
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4,
  parameter int CNT_W      = 32
) (
  input  logic             rx_user_clk_i,
  input  logic             rx_user_rst_i,
  input  logic [31:0]      rx_data_i,
  input  logic [1:0]       rx_vldb_i,
  input  logic             rx_valid_i,
  input  logic             rx_last_i,
  input  logic             rx_user_i,
  input  logic             clr_i,
  output logic             lock_o,
  output logic             err_pulse_o,
  output logic [CNT_W-1:0] err_bit_cnt_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [15:0]      bad_frame_cnt_o,
  output logic [15:0]      lock_loss_cnt_o
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W   = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Next 32 sequence bits after word w, using s[n] = s[n-31] ^ s[n-28].
  function automatic logic [31:0] prbs_next(input logic [31:0] w);
    logic [63:0] s;
    s = {32'd0, w};
    for (int j = 0; j < 32; j++) begin
      s[32+j] = s[1+j] ^ s[4+j];
    end
    return s[63:32];
  endfunction

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [5:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-5){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_w(input logic [CNT_W-1:0] a);
    return (a == {CNT_W{1'b1}}) ? a : a + CNT_W'(1);
  endfunction

  function automatic logic [15:0] sat_inc_16(input logic [15:0] a);
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction

  state_t             state, state_nxt;
  logic [31:0]        ref_q, ref_nxt;
  logic [MATCH_W-1:0] match_q, match_nxt;
  logic [BAD_W-1:0]   bad_q, bad_nxt;
  logic               pulse_nxt;
  logic               loss_nxt;
  logic [5:0]         err_add_nxt;

  logic [31:0]        mask_p0;
  logic [31:0]        expected_p0;
  logic [5:0]         err_p0;
  logic               full_p0;

  // Input stage: beat mask, prediction and error count for the current beat.
  always_comb begin
    mask_p0 = 32'hFFFF_FFFF;
    if (rx_last_i) begin
      case (rx_vldb_i)
        2'd1:    mask_p0 = 32'h0000_00FF;
        2'd2:    mask_p0 = 32'h0000_FFFF;
        2'd3:    mask_p0 = 32'h00FF_FFFF;
        default: mask_p0 = 32'hFFFF_FFFF;
      endcase
    end
  end

  assign full_p0     = (mask_p0 == 32'hFFFF_FFFF);
  assign expected_p0 = prbs_next(ref_q);
  assign err_p0      = popcount32((rx_data_i ^ expected_p0) & mask_p0);

  always_ff @(posedge rx_user_clk_i or posedge rx_user_rst_i) begin
    if (rx_user_rst_i) begin
      state   <= HUNT;
      ref_q   <= '0;
      match_q <= '0;
      bad_q   <= '0;
    end else begin
      state   <= state_nxt;
      ref_q   <= ref_nxt;
      match_q <= match_nxt;
      bad_q   <= bad_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ref_nxt     = ref_q;
    match_nxt   = match_q;
    bad_nxt     = bad_q;
    pulse_nxt   = 1'b0;
    loss_nxt    = 1'b0;
    err_add_nxt = '0;
    if (rx_valid_i) begin
      case (state)
        HUNT: begin
          // Only a full word can seed; a partial word would leave garbage
          // in the masked bytes of the reference.
          if (full_p0) begin
            ref_nxt   = rx_data_i;
            match_nxt = '0;
            state_nxt = VERIFY;
          end
        end
        VERIFY: begin
          ref_nxt = rx_data_i;
          if (err_p0 == 6'd0) begin
            if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
              state_nxt = LOCKED;
              match_nxt = '0;
              bad_nxt   = '0;
            end else begin
              match_nxt = match_q + MATCH_W'(1);
            end
          end else begin
            state_nxt = HUNT;
          end
        end
        LOCKED: begin
          // Free-run on the prediction so a corrupted word cannot poison
          // the following comparisons.
          ref_nxt = expected_p0;
          if (err_p0 != 6'd0) begin
            pulse_nxt   = 1'b1;
            err_add_nxt = err_p0;
            if (bad_q == BAD_W'(UNLOCK_CNT - 1)) begin
              state_nxt = HUNT;
              bad_nxt   = '0;
              loss_nxt  = 1'b1;
            end else begin
              bad_nxt = bad_q + BAD_W'(1);
            end
          end else begin
            bad_nxt = '0;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  assign lock_o = (state == LOCKED);

  // Output stage: registered pulse and counters; clear beats a same-cycle count.
  always_ff @(posedge rx_user_clk_i or posedge rx_user_rst_i) begin
    if (rx_user_rst_i) begin
      err_pulse_o     <= 1'b0;
      err_bit_cnt_o   <= '0;
      frame_cnt_o     <= '0;
      bad_frame_cnt_o <= '0;
      lock_loss_cnt_o <= '0;
    end else begin
      err_pulse_o <= pulse_nxt;
      if (clr_i) begin
        err_bit_cnt_o   <= '0;
        frame_cnt_o     <= '0;
        bad_frame_cnt_o <= '0;
        lock_loss_cnt_o <= '0;
      end else begin
        if (err_add_nxt != 6'd0) begin
          err_bit_cnt_o <= sat_add(err_bit_cnt_o, err_add_nxt);
        end
        if (rx_valid_i && rx_last_i) begin
          frame_cnt_o <= sat_inc_w(frame_cnt_o);
          if (rx_user_i) begin
            bad_frame_cnt_o <= sat_inc_16(bad_frame_cnt_o);
          end
        end
        if (loss_nxt) begin
          lock_loss_cnt_o <= sat_inc_16(lock_loss_cnt_o);
        end
      end
    end
  end

endmodule

// File: tb/tb_prbs_frame_checker.sv
// Bench for prbs_frame_checker: directed test-plan phases plus a randomized
// phase, with a scoreboard fed by a behavioural model of the checker.
module tb_prbs_frame_checker;

  localparam int LOCK_CNT   = 8;
  localparam int UNLOCK_CNT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rx_data = '0;
  logic [1:0]  rx_vldb = '0;
  logic        rx_valid = 1'b0;
  logic        rx_last = 1'b0;
  logic        rx_user = 1'b0;
  logic        clr = 1'b0;
  logic        lock;
  logic        err_pulse;
  logic [31:0] err_bit_cnt;
  logic [31:0] frame_cnt;
  logic [15:0] bad_frame_cnt;
  logic [15:0] lock_loss_cnt;

  prbs_frame_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .CNT_W(32)) dut (
    .rx_user_clk_i  (clk),
    .rx_user_rst_i  (rst),
    .rx_data_i      (rx_data),
    .rx_vldb_i      (rx_vldb),
    .rx_valid_i     (rx_valid),
    .rx_last_i      (rx_last),
    .rx_user_i      (rx_user),
    .clr_i          (clr),
    .lock_o         (lock),
    .err_pulse_o    (err_pulse),
    .err_bit_cnt_o  (err_bit_cnt),
    .frame_cnt_o    (frame_cnt),
    .bad_frame_cnt_o(bad_frame_cnt),
    .lock_loss_cnt_o(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        lock;
    logic        pulse;
    logic [31:0] ebits;
    logic [31:0] frames;
    logic [15:0] badf;
    logic [15:0] loss;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  bit   issued = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- stimulus generator: PRBS31 bit stream ----------------
  bit gbits[$];

  function automatic logic [31:0] gen_word();
    logic [31:0] w;
    if (gbits.size() == 0) begin
      w = 32'h7FFF_FFFF;
      for (int i = 0; i < 32; i++) gbits.push_back(w[i]);
      return w;
    end
    for (int j = 0; j < 32; j++) begin
      int n = gbits.size();
      gbits.push_back(gbits[n-31] ^ gbits[n-28]);
    end
    for (int j = 0; j < 32; j++) void'(gbits.pop_front());
    for (int i = 0; i < 32; i++) w[i] = gbits[i];
    return w;
  endfunction

  // ---------------- behavioural reference model ----------------
  int          m_state;  // 0 hunting, 1 verifying, 2 locked
  logic [31:0] m_ref;
  int          m_match, m_bad;
  logic [31:0] m_ebits, m_frames;
  logic [15:0] m_badf, m_loss;

  function automatic logic [31:0] predict(input logic [31:0] w);
    bit s[64];
    logic [31:0] r;
    for (int i = 0; i < 32; i++) s[i] = w[i];
    for (int n = 32; n < 64; n++) s[n] = s[n-31] ^ s[n-28];
    for (int i = 0; i < 32; i++) r[i] = s[32+i];
    return r;
  endfunction

  function automatic void m_reset();
    m_state = 0; m_ref = '0; m_match = 0; m_bad = 0;
    m_ebits = '0; m_frames = '0; m_badf = '0; m_loss = '0;
  endfunction

  function automatic void model_step(input bit v, input logic [31:0] d, input bit last,
                                     input logic [1:0] vldb, input bit user, input bit c);
    logic [31:0] mask, ex;
    longint      sum;
    int          e;
    bit          pulse = 0;
    exp_t        x;
    mask = (last && vldb != 0) ? (32'hFFFF_FFFF >> (8 * (4 - int'(vldb)))) : 32'hFFFF_FFFF;
    if (v) begin
      ex = predict(m_ref);
      e  = $countones((d ^ ex) & mask);
      if (m_state == 0) begin
        if (mask == 32'hFFFF_FFFF) begin m_ref = d; m_match = 0; m_state = 1; end
      end else if (m_state == 1) begin
        m_ref = d;
        if (e == 0) begin
          m_match++;
          if (m_match == LOCK_CNT) begin m_state = 2; m_bad = 0; end
        end else m_state = 0;
      end else begin
        m_ref = ex;
        if (e != 0) begin
          pulse = 1;
          sum = longint'(m_ebits) + e;
          m_ebits = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
          m_bad++;
          if (m_bad == UNLOCK_CNT) begin
            m_state = 0; m_bad = 0;
            if (m_loss != 16'hFFFF) m_loss++;
          end
        end else m_bad = 0;
      end
      if (last) begin
        if (m_frames != 32'hFFFF_FFFF) m_frames++;
        if (user && m_badf != 16'hFFFF) m_badf++;
      end
    end
    if (c) begin m_ebits = 0; m_frames = 0; m_badf = 0; m_loss = 0; end
    x.lock = (m_state == 2); x.pulse = pulse; x.ebits = m_ebits;
    x.frames = m_frames; x.badf = m_badf; x.loss = m_loss;
    sbq.push_back(x);
  endfunction

  // ---------------- drivers ----------------
  task automatic beat(input logic [31:0] d, input bit last = 0, input logic [1:0] vldb = 0,
                      input bit user = 0, input bit c = 0);
    @(posedge clk); #1;
    rx_valid = 1; rx_data = d; rx_last = last; rx_vldb = vldb; rx_user = user; clr = c;
    issued = 1;
    model_step(1, d, last, vldb, user, c);
  endtask

  task automatic idle(input bit c = 0);
    @(posedge clk); #1;
    rx_valid = 0; rx_data = $urandom; rx_last = 1'($urandom); rx_vldb = 2'($urandom);
    rx_user = 1'($urandom); clr = c;
    issued = 1;
    model_step(0, rx_data, rx_last, rx_vldb, rx_user, c);
  endtask

  task automatic clean_beats(input int n);
    for (int i = 0; i < n; i++) begin
      beat(gen_word());
      if ($urandom_range(0, 3) == 0) idle();
    end
  endtask

  // Stop driving, let the last beat land, then sample away from the edge.
  task automatic settle();
    @(posedge clk); #1;
    rx_valid = 0; clr = 0; issued = 0;
    @(posedge clk); #2;
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (issued) begin
        #2;
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow actual=empty required=entry t=%0t", $time);
        end else begin
          e = sbq.pop_front();
          chk("sb_lock", 32'(lock), 32'(e.lock));
          chk("sb_pulse", 32'(err_pulse), 32'(e.pulse));
          chk("sb_ebits", err_bit_cnt, e.ebits);
          chk("sb_frames", frame_cnt, e.frames);
          chk("sb_badf", 32'(bad_frame_cnt), 32'(e.badf));
          chk("sb_loss", 32'(lock_loss_cnt), 32'(e.loss));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] w, saved_e, saved_f;
    m_reset();
    #12;
    chk("rst_lock", 32'(lock), 0);
    chk("rst_ebits", err_bit_cnt, 0);
    chk("rst_frames", frame_cnt, 0);
    chk("rst_pulse", 32'(err_pulse), 0);
    @(negedge clk); rst = 0;

    // Clean stream: seed plus eight matches locks.
    clean_beats(8);
    settle();
    chk("lock_after8", 32'(lock), 0);
    clean_beats(1);
    settle();
    chk("lock_after9", 32'(lock), 1);
    clean_beats(11);
    settle();
    chk("clean_ebits", err_bit_cnt, 0);

    // Two-bit error while locked.
    beat(gen_word() ^ 32'h0002_0001);
    clean_beats(2);
    settle();
    chk("flip_ebits", err_bit_cnt, 2);
    chk("flip_lock", 32'(lock), 1);

    // Four zero words drop lock.
    for (int i = 0; i < 4; i++) begin w = gen_word(); beat(32'h0); end
    settle();
    chk("unlock_lock", 32'(lock), 0);
    chk("unlock_loss", 32'(lock_loss_cnt), 1);
    clean_beats(8);
    settle();
    chk("relock8", 32'(lock), 0);
    clean_beats(1);
    settle();
    chk("relock9", 32'(lock), 1);

    // Partial last beats: masked bytes ignored, valid bytes checked.
    saved_e = m_ebits; saved_f = m_frames;
    beat(gen_word() ^ 32'hA5C3_0000, 1, 2'd2);
    settle();
    chk("partial_masked_ebits", err_bit_cnt, saved_e);
    chk("partial_frames", frame_cnt, saved_f + 1);
    beat(gen_word() ^ 32'h0000_0800, 1, 2'd2);
    settle();
    chk("partial_bit_ebits", err_bit_cnt, saved_e + 1);

    // PCS bad frame, then clear coincident with a last beat.
    saved_f = m_frames;
    beat(gen_word(), 1, 2'd0, 1);
    settle();
    chk("badf_count", 32'(bad_frame_cnt), 1);
    chk("badf_frames", frame_cnt, saved_f + 1);
    clean_beats(3);
    beat(gen_word() ^ 32'h0000_0010, 1, 2'd0, 1, 1);
    settle();
    chk("clr_ebits", err_bit_cnt, 0);
    chk("clr_frames", frame_cnt, 0);
    chk("clr_badf", 32'(bad_frame_cnt), 0);
    chk("clr_loss", 32'(lock_loss_cnt), 0);
    chk("clr_lock", 32'(lock), 1);

    // Randomized traffic with sporadic bit flips, garbage bursts and clears.
    for (int i = 0; i < 400; i++) begin
      int          r;
      bit          last;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        for (int k = 0; k < 5; k++) begin w = gen_word(); beat($urandom); end
      end else begin
        w = gen_word();
        if (r < 12) w = w ^ (32'h1 << $urandom_range(0, 31));
        else if (r < 15) w = w ^ 32'($urandom);
        last = ($urandom_range(0, 5) == 0);
        beat(w, last, 2'($urandom), 1'($urandom), $urandom_range(0, 60) == 0);
      end
      if ($urandom_range(0, 4) == 0) idle($urandom_range(0, 20) == 0);
    end

    // Lock, then reset asynchronously in the middle of a frame.
    clean_beats(20);
    settle();
    chk("prereset_lock", 32'(lock), 1);
    clean_beats(3);
    settle();
    @(negedge clk); rst = 1;
    #1;
    chk("async_lock", 32'(lock), 0);
    chk("async_ebits", err_bit_cnt, 0);
    chk("async_frames", frame_cnt, 0);
    chk("async_loss", 32'(lock_loss_cnt), 0);
    m_reset();
    @(negedge clk); rst = 0;
    beat(gen_word(), 1, 2'd1);
    settle();
    chk("partial_noseed", 32'(lock), 0);
    clean_beats(8);
    settle();
    chk("reseed8", 32'(lock), 0);
    clean_beats(1);
    settle();
    chk("reseed9", 32'(lock), 1);

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
